// File: rtl/sd_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sd_spi_pkg
//  Purpose  : Shared types, command indices, R1 bit positions and the CRC7
//             helper for the SD-card SPI-mode command engine.
//  Revision : 1.0  initial release
// ============================================================================
package sd_spi_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SEND   = 3'd2,
    ST_WAIT_R = 3'd3,
    ST_RECV   = 3'd4,
    ST_TRAIL  = 3'd5
  } sd_state_t;

  localparam logic [5:0] CMD_GO_IDLE       = 6'd0;
  localparam logic [5:0] CMD_SEND_IF_COND  = 6'd8;
  localparam logic [5:0] CMD_APP           = 6'd55;
  localparam logic [5:0] ACMD_SEND_OP_COND = 6'd41;
  localparam logic [5:0] CMD_READ_OCR      = 6'd58;

  // R1 response bit positions; bit 7 is always 0 in a valid R1.
  localparam int R1_IN_IDLE      = 0;
  localparam int R1_ERASE_RESET  = 1;
  localparam int R1_ILLEGAL_CMD  = 2;
  localparam int R1_CRC_ERR      = 3;
  localparam int R1_ERASE_SEQ    = 4;
  localparam int R1_ADDR_ERR     = 5;
  localparam int R1_PARAM_ERR    = 6;
  localparam int R1_START_BIT    = 7;

  // CRC7 (x^7 + x^3 + 1) over the 40 header bits, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_spi_sck_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sd_spi_sck_gen
//  Purpose  : Mode-0 SCK divider. Holds SCK low while not running; flags the
//             clk on which SCK rises and the clk after SCK falls.
//  Revision : 1.0  initial release
// ============================================================================
module sd_spi_sck_gen #(
  parameter int SLOW_HALF = 125,
  parameter int FAST_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic fast,
  output logic sclk,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CNT_W = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;

  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] half_m1;
  logic             terminal;

  assign half_m1    = fast ? CNT_W'(FAST_HALF - 1) : CNT_W'(SLOW_HALF - 1);
  assign terminal   = run && (div_cnt == half_m1);
  // Asserted on the very clk edge that drives SCK high: MISO sample point.
  assign rise_pulse = terminal && !sclk;

  // Half-period divider; fall_pulse is delayed one clk so MOSI moves after SCK falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      sclk       <= 1'b0;
      fall_pulse <= 1'b0;
    end else if (!run) begin
      div_cnt    <= '0;
      sclk       <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      fall_pulse <= terminal && sclk;
      if (terminal) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sd_spi_cmd_engine.sv
`default_nettype none
// ============================================================================
//  Module   : sd_spi_cmd_engine
//  Purpose  : SD-card SPI-mode command engine: power-up dummy clocks, 48-bit
//             command framing, R1 / R3 / R7 capture with NCR timeout.
//  Options  : SD_SPI_CRC7_EN - compute CRC7 for every command; otherwise a
//             fixed CRC is used (valid for CMD0 / CMD8 only).
//  Revision : 1.0  initial release
// ============================================================================
module sd_spi_cmd_engine
  import sd_spi_pkg::*;
#(
  parameter int CLK_HZ        = 100000000,
  parameter int SLOW_HZ       = 400000,
  parameter int FAST_HZ       = 25000000,
  parameter int INIT_CLOCKS   = 80,
  parameter int NCR_MAX_BYTES = 8,
  parameter int TRAIL_CLOCKS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fast_mode,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        resp_long,
  input  logic        keep_cs,
  output logic        resp_valid,
  output logic        resp_timeout,
  output logic [39:0] resp_data,
  output logic        sd_cclk,
  output logic        sd_cmd,
  input  logic        sd_data0,
  output logic        sd_cs
);

  localparam int SLOW_HALF = CLK_HZ / (2 * SLOW_HZ);
  localparam int FAST_HALF = CLK_HZ / (2 * FAST_HZ);
  localparam int NCR_W     = $clog2(NCR_MAX_BYTES + 1);
  localparam int INIT_W    = $clog2(INIT_CLOCKS + 1);

  sd_state_t         state, state_next;
  logic [47:0]       frame_sr;
  logic [5:0]        bit_cnt;
  logic [NCR_W-1:0]  ncr_cnt;
  logic [INIT_W-1:0] init_cnt;
  logic [39:0]       resp_sr;
  logic              long_q, keep_q, fast_q, timeout_q;
  logic              sck_run, accept, rise, fall;
  logic [6:0]        crc_sel;
  logic [47:0]       frame_new;
  logic [7:0]        byte_in;

  assign cmd_ready = (state == ST_IDLE);
  assign byte_in   = {resp_sr[6:0], sd_data0};
  assign frame_new = {2'b01, cmd_index, cmd_arg, crc_sel, 1'b1};

`ifdef SD_SPI_CRC7_EN
  assign crc_sel = crc7({2'b01, cmd_index, cmd_arg});
`else
  // Fixed CRC: SPI mode only checks it on CMD0 and CMD8.
  always_comb begin
    crc_sel = 7'h00;
    if (cmd_index == CMD_GO_IDLE)      crc_sel = 7'h4A;
    if (cmd_index == CMD_SEND_IF_COND) crc_sel = 7'h43;
  end
`endif

  sd_spi_sck_gen #(
    .SLOW_HALF (SLOW_HALF),
    .FAST_HALF (FAST_HALF)
  ) u_sck (
    .clk        (clk),
    .rst        (rst),
    .run        (sck_run),
    .fast       (fast_q && (state != ST_INIT)),
    .sclk       (sd_cclk),
    .rise_pulse (rise),
    .fall_pulse (fall)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INIT;
    else     state <= state_next;
  end

  // Next-state decode, SCK enable and command accept strobe.
  always_comb begin
    state_next = state;
    sck_run    = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_INIT: begin
        sck_run = 1'b1;
        if (fall && (init_cnt == INIT_W'(INIT_CLOCKS - 1))) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        sck_run = 1'b1;
        if (fall && (bit_cnt == 6'd47)) state_next = ST_WAIT_R;
      end
      ST_WAIT_R: begin
        sck_run = 1'b1;
        if (rise && (bit_cnt == 6'd7)) begin
          if (!byte_in[R1_START_BIT])
            state_next = long_q ? ST_RECV : ST_TRAIL;
          else if (ncr_cnt == NCR_W'(NCR_MAX_BYTES - 1))
            state_next = ST_TRAIL;
        end
      end
      ST_RECV: begin
        sck_run = 1'b1;
        if (rise && (bit_cnt == 6'd31)) state_next = ST_TRAIL;
      end
      ST_TRAIL: begin
        sck_run = 1'b1;
        if (fall && (bit_cnt == 6'(TRAIL_CLOCKS))) state_next = ST_IDLE;
      end
      default: state_next = ST_INIT;
    endcase
  end

  // Datapath: frame shifter, response capture, counters and pin registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_sr     <= '0;
      bit_cnt      <= '0;
      ncr_cnt      <= '0;
      init_cnt     <= '0;
      resp_sr      <= '0;
      long_q       <= 1'b0;
      keep_q       <= 1'b0;
      fast_q       <= 1'b0;
      timeout_q    <= 1'b0;
      sd_cs        <= 1'b1;
      sd_cmd       <= 1'b1;
      resp_valid   <= 1'b0;
      resp_timeout <= 1'b0;
      resp_data    <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_INIT: begin
          sd_cs  <= 1'b1;
          sd_cmd <= 1'b1;
          if (fall) init_cnt <= init_cnt + 1'b1;
        end
        ST_IDLE: begin
          if (accept) begin
            frame_sr  <= {frame_new[46:0], 1'b0};
            sd_cmd    <= frame_new[47];
            sd_cs     <= 1'b0;
            long_q    <= resp_long;
            keep_q    <= keep_cs;
            fast_q    <= fast_mode;
            timeout_q <= 1'b0;
            bit_cnt   <= '0;
            ncr_cnt   <= '0;
            resp_sr   <= '0;
          end
        end
        ST_SEND: begin
          if (fall) begin
            if (bit_cnt == 6'd47) begin
              sd_cmd  <= 1'b1;
              bit_cnt <= '0;
            end else begin
              sd_cmd   <= frame_sr[47];
              frame_sr <= {frame_sr[46:0], 1'b0};
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
        end
        ST_WAIT_R: begin
          sd_cmd <= 1'b1;
          if (rise) begin
            resp_sr <= {32'h0, byte_in};
            if (bit_cnt == 6'd7) begin
              bit_cnt <= '0;
              if (byte_in[R1_START_BIT]) begin
                ncr_cnt <= ncr_cnt + 1'b1;
                if (ncr_cnt == NCR_W'(NCR_MAX_BYTES - 1)) begin
                  timeout_q <= 1'b1;
                  resp_sr   <= long_q ? 40'hFF_0000_0000 : 40'h00_0000_00FF;
                end
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (rise) begin
            resp_sr <= {resp_sr[38:0], sd_data0};
            bit_cnt <= (bit_cnt == 6'd31) ? 6'd0 : bit_cnt + 1'b1;
          end
        end
        ST_TRAIL: begin
          sd_cmd <= 1'b1;
          if (rise) bit_cnt <= bit_cnt + 1'b1;
          if (fall && (bit_cnt == 6'(TRAIL_CLOCKS))) begin
            if (!keep_q) sd_cs <= 1'b1;
            resp_valid   <= 1'b1;
            resp_timeout <= timeout_q;
            resp_data    <= resp_sr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
